mem_dbus_ctrl: RTL and testbench

Data-side bus master behind the MEM stage. It reads the load/store request that the MEM stage derives from the EX/MEM pipeline register (address, write data, byte selects, direction) and runs a single-beat Wishbone classic transaction. While the transaction is outstanding it holds the pipeline through `stallreq_o`; it returns load data to MEM. It honours `stall`/`flush` from `ctrl` and reports bus errors and timeouts to the exception logic.

---
 rtl/mem_dbus_ctrl_pkg.sv | 21 ++
 rtl/mem_dbus_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_dbus_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dbus_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the MEM-stage Wishbone data master.
package mem_dbus_ctrl_pkg;

  localparam logic        RstEnable      = 1'b1;
  localparam logic [31:0] ZeroWord       = 32'h0000_0000;
  localparam logic        Stop           = 1'b1;
  localparam logic        NoStop         = 1'b0;
  localparam int          TimeoutDefault = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BUSY       = 2'd1,
    ST_WAIT_STALL = 2'd2
  } bus_state_e;

  // Stores never return data to the pipeline.
  function automatic logic [31:0] load_data(input logic we, input logic [31:0] d);
    return we ? ZeroWord : d;
  endfunction

endpackage

// File: rtl/mem_dbus_ctrl.sv
// Single-beat Wishbone classic master for MEM-stage loads/stores; holds the
// pipeline through stallreq_o while the access is outstanding.
module mem_dbus_ctrl
  import mem_dbus_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TimeoutDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [1:0]  dbg_state_o
);

  localparam int CntW = $clog2(TIMEOUT) + 1;

  bus_state_e      r_state;
  logic [CntW-1:0] r_cnt;
  logic [31:0]     r_rd_buf;
  logic            r_err;
  logic [31:0]     r_wb_adr;
  logic [31:0]     r_wb_dat;
  logic [3:0]      r_wb_sel;
  logic            r_wb_we;
  logic            r_wb_cyc;

  logic w_timeout;
  logic w_fail;
  logic w_done;
  logic w_accept;

  // Handshake: cpu_ce_i is the request valid; the pipeline may advance past the
  // access only in a cycle where stallreq_o is low, which is the completion
  // (ack/err/timeout) cycle, a flush, or any cycle with no request pending.
  assign w_accept  = cpu_ce_i & ~flush_i;
  assign w_timeout = (r_cnt == CntW'(TIMEOUT - 1));
  // An err/ack tie is an error; a timeout only counts if the slave stays silent.
  assign w_fail    = wb_err_i | (w_timeout & ~wb_ack_i);
  assign w_done    = wb_ack_i | w_fail;

  always_comb begin
    stallreq_o = NoStop;
    bus_err_o  = 1'b0;
    cpu_data_o = ZeroWord;
    case (r_state)
      ST_IDLE: begin
        stallreq_o = w_accept ? Stop : NoStop;
      end
      ST_BUSY: begin
        if (!flush_i) begin
          if (w_fail) begin
            bus_err_o = 1'b1;
          end else if (wb_ack_i) begin
            cpu_data_o = load_data(r_wb_we, wb_dat_i);
          end else begin
            stallreq_o = Stop;
          end
        end
      end
      ST_WAIT_STALL: begin
        cpu_data_o = r_rd_buf;
        bus_err_o  = r_err;
      end
      default: begin
        stallreq_o = NoStop;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_rd_buf <= ZeroWord;
      r_err    <= 1'b0;
      r_wb_adr <= ZeroWord;
      r_wb_dat <= ZeroWord;
      r_wb_sel <= 4'h0;
      r_wb_we  <= 1'b0;
      r_wb_cyc <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_wb_adr <= cpu_addr_i;
            r_wb_dat <= cpu_data_i;
            r_wb_sel <= cpu_sel_i;
            r_wb_we  <= cpu_we_i;
            r_wb_cyc <= 1'b1;
            r_cnt    <= '0;
            r_state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + CntW'(1);
          if (flush_i) begin
            r_wb_cyc <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (w_done) begin
            r_wb_cyc <= 1'b0;
            r_rd_buf <= w_fail ? ZeroWord : load_data(r_wb_we, wb_dat_i);
            r_err    <= w_fail;
            r_state  <= (|stall_i) ? ST_WAIT_STALL : ST_IDLE;
          end
        end
        ST_WAIT_STALL: begin
          if (flush_i || !(|stall_i)) begin
            r_err   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_wb_cyc <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign wb_adr_o    = r_wb_adr;
  assign wb_dat_o    = r_wb_dat;
  assign wb_sel_o    = r_wb_sel;
  assign wb_we_o     = r_wb_we;
  assign wb_cyc_o    = r_wb_cyc;
  assign wb_stb_o    = r_wb_cyc;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Self-checking bench for mem_dbus_ctrl: directed test-plan scenarios plus
// randomized transactions checked against a per-transaction timeline model.
module tb_mem_dbus_ctrl;
  import mem_dbus_ctrl_pkg::*;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
  logic [3:0]  cpu_sel_i;
  logic        stallreq_o, bus_err_o;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_i;
  logic [1:0]  dbg_state_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  mem_dbus_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o),
    .stall_i(stall_i), .flush_i(flush_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_quiet();
    cpu_ce_i   = 1'b0;
    cpu_we_i   = 1'b0;
    cpu_addr_i = '0;
    cpu_sel_i  = '0;
    cpu_data_i = '0;
    stall_i    = '0;
    flush_i    = 1'b0;
    wb_dat_i   = '0;
    wb_ack_i   = 1'b0;
    wb_err_i   = 1'b0;
  endtask

  task automatic drive_junk_cpu();
    cpu_ce_i   = 1'($urandom_range(0, 1));
    cpu_we_i   = 1'($urandom_range(0, 1));
    cpu_addr_i = $urandom;
    cpu_sel_i  = 4'($urandom);
    cpu_data_i = $urandom;
  endtask

  task automatic test_reset();
    drive_quiet();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o} !== 71'd0 ||
        {stallreq_o, bus_err_o, cpu_data_o} !== 34'd0 || dbg_state_o !== 2'(ST_IDLE)) begin
      n_err++;
      $display("FAIL reset: adr=%h dat=%h sel=%h we/stb/cyc=%b%b%b stallreq=%b err=%b data=%h state=%0d, all must be 0",
               wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
               stallreq_o, bus_err_o, cpu_data_o, dbg_state_o);
    end
    tick();
  endtask

  // One full transaction. k: cycle offset of the slave response (k>T: silent slave).
  // hold: number of WAIT_STALL cycles after completion. fl: BUSY cycle carrying flush (0: none).
  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel,
                         input logic [31:0] rdata, input int k, input logic use_err,
                         input logic tie, input int hold, input logic [5:0] sv, input int fl);
    int c, last;
    logic err;
    logic [31:0] dexp;
    logic [3:0] st_exp;
    logic [31:0] d_exp;
    c    = (k <= T) ? k : T;
    last = (fl != 0) ? fl : c;
    err  = (k > T) || use_err;
    dexp = (err || we) ? 32'h0 : rdata;

    drive_quiet();
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = wdata;
    @(negedge clk);
    n_vec++;
    if ({stallreq_o, bus_err_o, wb_cyc_o, cpu_data_o} !== {3'b100, 32'h0}) begin
      n_err++;
      $display("FAIL %s request: stallreq/err/cyc=%b%b%b data=%h, need 100 data=0",
               name, stallreq_o, bus_err_o, wb_cyc_o, cpu_data_o);
    end
    tick();

    for (int t = 1; t <= last; t++) begin
      drive_junk_cpu();
      stall_i  = 6'($urandom);
      flush_i  = 1'b0;
      wb_dat_i = $urandom;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (t == last && fl != 0) begin
        flush_i  = 1'b1;
        wb_ack_i = 1'($urandom_range(0, 1));
      end else if (t == last && k <= T) begin
        wb_ack_i = !use_err || tie;
        wb_err_i = use_err;
        wb_dat_i = rdata;
      end
      if (t == last && fl == 0) begin
        stall_i = (hold > 0) ? ((sv != 0) ? sv : 6'($urandom_range(1, 63))) : 6'd0;
        exp_q.push_back(dexp);
      end
      if (t < last)        begin st_exp = 4'b1011;            d_exp = 32'h0; end
      else if (fl != 0)    begin st_exp = 4'b0011;            d_exp = 32'h0; end
      else                 begin st_exp = {1'b0, err, 2'b11}; d_exp = exp_q[0]; end
      @(negedge clk);
      n_vec++;
      if ({stallreq_o, bus_err_o, wb_cyc_o, wb_stb_o} !== st_exp || cpu_data_o !== d_exp) begin
        n_err++;
        $display("FAIL %s busy t=%0d: stallreq/err/cyc/stb=%b data=%h, need %b data=%h",
                 name, t, {stallreq_o, bus_err_o, wb_cyc_o, wb_stb_o}, cpu_data_o, st_exp, d_exp);
      end
      n_vec++;
      if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o} !== {addr, wdata, sel, we}) begin
        n_err++;
        $display("FAIL %s bus t=%0d: adr=%h dat=%h sel=%h we=%b, need %h %h %h %b",
                 name, t, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, addr, wdata, sel, we);
      end
      tick();
    end

    for (int w = 1; w <= hold && fl == 0; w++) begin
      drive_junk_cpu();
      stall_i = (w < hold) ? ((sv != 0) ? sv : 6'($urandom_range(1, 63))) : 6'd0;
      @(negedge clk);
      n_vec++;
      if ({stallreq_o, bus_err_o, wb_cyc_o, wb_stb_o} !== {1'b0, err, 2'b00} ||
          cpu_data_o !== exp_q[0]) begin
        n_err++;
        $display("FAIL %s wait w=%0d: stallreq/err/cyc/stb=%b data=%h, need %b data=%h",
                 name, w, {stallreq_o, bus_err_o, wb_cyc_o, wb_stb_o}, cpu_data_o,
                 {1'b0, err, 2'b00}, exp_q[0]);
      end
      tick();
    end
    if (fl == 0) void'(exp_q.pop_front());

    // Back in IDLE: a late ack after a flush must have no visible effect.
    drive_quiet();
    if (fl != 0) begin
      wb_ack_i = 1'b1;
      wb_dat_i = $urandom;
    end
    @(negedge clk);
    n_vec++;
    if ({stallreq_o, bus_err_o, wb_cyc_o, wb_stb_o, cpu_data_o} !== 36'd0) begin
      n_err++;
      $display("FAIL %s idle: stallreq/err/cyc/stb=%b data=%h, need 0000 data=0",
               name, {stallreq_o, bus_err_o, wb_cyc_o, wb_stb_o}, cpu_data_o);
    end
    tick();
    drive_quiet();
  endtask

  task automatic test_idle_flush();
    drive_quiet();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h40; cpu_sel_i = 4'hF; flush_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if (stallreq_o !== 1'b0) begin
      n_err++;
      $display("FAIL idle_flush stallreq: got %b need 0", stallreq_o);
    end
    tick();
    drive_quiet();
    @(negedge clk);
    n_vec++;
    if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_flush cyc/stb: got %b%b need 00", wb_cyc_o, wb_stb_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    drive_quiet();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h300; cpu_sel_i = 4'hC; cpu_data_i = 32'hCAFEF00D;
    tick();
    drive_quiet();
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (wb_cyc_o !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid pre-edge cyc: got %b need 1", wb_cyc_o);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o} !== 71'd0 ||
        dbg_state_o !== 2'(ST_IDLE)) begin
      n_err++;
      $display("FAIL rst_mid: adr=%h dat=%h sel=%h we/stb/cyc=%b%b%b state=%0d, need all 0",
               wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o, dbg_state_o);
    end
    rst = 1'b0;
    tick();
    run_txn("after_rst", 1'b0, 32'h304, 32'h0, 4'hF, 32'h0BADC0DE, 2, 1'b0, 1'b0, 0, 6'd0, 0);
  endtask

  task automatic test_plan();
    run_txn("load_ack3",   1'b0, 32'h100, 32'h0,        4'hF,    32'h12345678, 3,     1'b0, 1'b0, 0, 6'd0,       0);
    run_txn("store_zw",    1'b1, 32'h204, 32'hDEADBEEF, 4'b0011, 32'h55555555, 1,     1'b0, 1'b0, 0, 6'd0,       0);
    run_txn("wait_stall",  1'b0, 32'h208, 32'h0,        4'hF,    32'hA5A5A5A5, 2,     1'b0, 1'b0, 3, 6'b000111,  0);
    run_txn("flush_busy",  1'b0, 32'h20C, 32'h0,        4'hF,    32'h11111111, 5,     1'b0, 1'b0, 0, 6'd0,       2);
    run_txn("timeout",     1'b0, 32'h210, 32'h0,        4'hF,    32'h22222222, T + 1, 1'b0, 1'b0, 0, 6'd0,       0);
    run_txn("wb_err",      1'b0, 32'h214, 32'h0,        4'hF,    32'h33333333, 2,     1'b1, 1'b0, 0, 6'd0,       0);
    run_txn("err_ack_tie", 1'b0, 32'h218, 32'h0,        4'hF,    32'h44444444, 3,     1'b1, 1'b1, 2, 6'd0,       0);
    run_txn("ack_last",    1'b0, 32'h21C, 32'h0,        4'hF,    32'h66666666, T,     1'b0, 1'b0, 0, 6'd0,       0);
    run_txn("timeout_wait",1'b1, 32'h220, 32'h77777777, 4'h1,    32'h0,        T + 2, 1'b0, 1'b0, 2, 6'd0,       0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int k, fl;
      k  = $urandom_range(1, T + 3);
      fl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, (k <= T) ? k : T) : 0;
      run_txn("random", 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
              $urandom, k, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 6'd0, fl);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_quiet();
    test_reset();
    test_plan();
    test_idle_flush();
    test_reset_mid_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
